// File: rtl/serial_link_pkg.sv
// ============================================================================
// Module      : serial_link_pkg
// Description : Shared types and constants for the serial debug/IO link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int   DEFAULT_DATA_W = 8;
    localparam logic PARITY_EVEN    = 1'b0;
    localparam logic PARITY_ODD     = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_parity_rx_parity_accum.sv
// ============================================================================
// Module      : parity_accum
// Description : 1-bit XOR accumulator with synchronous clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_accum (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);

    logic r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= 1'b0;
        end else if (clr) begin
            r_acc <= 1'b0;
        end else if (en) begin
            r_acc <= r_acc ^ din;
        end
    end

    assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/serial_parity_rx.sv
// ============================================================================
// Module      : serial_parity_rx
// Description : Strobe-sampled serial receiver with parity/frame checking and
//               a valid/ready output. SERIAL_PARITY_ODD_EN selects odd parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_rx
    import serial_link_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx,
    input  logic              bit_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DATA_W - 1);
`ifdef SERIAL_PARITY_ODD_EN
    localparam logic c_expect = PARITY_ODD;
`else
    localparam logic c_expect = PARITY_EVEN;
`endif

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              w_start;
    logic              w_data_smp;
    logic              w_acc_en;
    logic              w_stop_smp;
    logic              w_par_acc;
    logic              w_can_load;
    logic              w_accept;

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_overrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_data_smp  = 1'b0;
        w_acc_en    = 1'b0;
        w_stop_smp  = 1'b0;
        if (bit_en) begin
            case (r_state)
                IDLE: begin
                    if (!rx) begin
                        w_start     = 1'b1;
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    w_data_smp = 1'b1;
                    w_acc_en   = 1'b1;
                    if (r_cnt == c_last_idx) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    // Folding the parity bit into the accumulator leaves the
                    // error flag as a single XOR against the expected sense.
                    w_acc_en    = 1'b1;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_stop_smp  = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (w_data_smp) begin
            r_shift[r_cnt] <= rx;
            r_cnt          <= r_cnt + 1'b1;
        end
    end

    parity_accum u_parity_accum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_start),
        .en      (w_acc_en),
        .din     (rx),
        .acc     (w_par_acc)
    );

    assign w_accept   = r_out_valid & out_ready;
    assign w_can_load = ~r_out_valid | out_ready;

    // A commit that coincides with an accept loads the new word and also
    // clears overrun, since the stale word has just been consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_stop_smp && w_can_load) begin
                r_out_data   <= r_shift;
                r_parity_err <= w_par_acc ^ c_expect;
                r_frame_err  <= ~rx;
                r_out_valid  <= 1'b1;
            end else if (w_stop_smp) begin
                r_overrun <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
// ============================================================================
// Module      : tb_serial_parity_rx
// Description : Directed self-checking bench for serial_parity_rx (DATA_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_parity_rx;

`ifdef SERIAL_PARITY_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       bit_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    serial_parity_rx #(.DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .bit_en     (bit_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_perr_even;
        logic       exp_fe;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bit_en strobe; rx is scrambled during gap cycles, which must be ignored.
    task automatic strobe(input logic b, input int gap);
        rx     = b;
        bit_en = 1'b1;
        @(posedge clk); #1;
        bit_en = 1'b0;
        rx     = ~b;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_head(input logic [7:0] d, input logic par, input int gap);
        strobe(1'b0, gap);
        for (int i = 0; i < 8; i++) strobe(d[i], gap);
        strobe(par, gap);
    endtask

    // Returns #1 after the stop-strobe edge, i.e. when the commit is visible.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int gap);
        send_head(d, par, gap);
        strobe(stop, 0);
        rx = 1'b1;
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ ODD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1};

        reset_n   = 1'b0;
        rx        = 1'b1;
        bit_en    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_perr", 32'(parity_err), 0);
        check("rst_fe", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            send_head(vecs[v].data, vecs[v].par, v % 2);
            check("pre_commit_valid", 32'(out_valid), 0);
            strobe(vecs[v].stop, 0);
            rx = 1'b1;
            check("vec_valid", 32'(out_valid), 1);
            check("vec_data", 32'(out_data), 32'(vecs[v].data));
            check("vec_perr", 32'(parity_err), 32'(vecs[v].exp_perr_even ^ ODD));
            check("vec_fe", 32'(frame_err), 32'(vecs[v].exp_fe));
            check("vec_ovr", 32'(overrun), 0);
            @(posedge clk); #1;
            check("vec_valid_drop", 32'(out_valid), 0);
            check("vec_data_hold", 32'(out_data), 32'(vecs[v].data));
            repeat (2) @(posedge clk);
            #1;
        end

        // Overrun: second frame dropped while first is unaccepted.
        out_ready = 1'b0;
        send_frame(8'h11, good_par(8'h11), 1'b1, 0);
        check("ovr_first_valid", 32'(out_valid), 1);
        check("ovr_first_data", 32'(out_data), 32'h11);
        send_frame(8'h22, 1'b1, 1'b0, 1);
        check("ovr_hold_data", 32'(out_data), 32'h11);
        check("ovr_hold_perr", 32'(parity_err), 0);
        check("ovr_hold_fe", 32'(frame_err), 0);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_valid", 32'(out_valid), 1);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_sticky", 32'(overrun), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("ovr_accept_valid", 32'(out_valid), 0);
        check("ovr_accept_clr", 32'(overrun), 0);
        check("ovr_accept_data", 32'(out_data), 32'h11);

        // Reset mid-frame: abandoned, then a clean frame follows.
        strobe(1'b0, 1);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_data", 32'(out_data), 0);
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_ovr", 32'(overrun), 0);
        rx = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h5A, good_par(8'h5A), 1'b1, 1);
        check("mid_rst_valid", 32'(out_valid), 1);
        check("mid_rst_data", 32'(out_data), 32'h5A);
        check("mid_rst_perr", 32'(parity_err), 0);
        check("mid_rst_fe", 32'(frame_err), 0);
        @(posedge clk); #1;
        check("mid_rst_drop", 32'(out_valid), 0);

        // Accept and commit on the same edge, with overrun set beforehand.
        out_ready = 1'b0;
        send_frame(8'h33, good_par(8'h33), 1'b1, 0);
        send_frame(8'h44, good_par(8'h44), 1'b1, 0);
        check("same_pre_ovr", 32'(overrun), 1);
        check("same_pre_data", 32'(out_data), 32'h33);
        send_head(8'hC3, ~good_par(8'hC3), 0);
        out_ready = 1'b1;
        strobe(1'b0, 0);
        rx = 1'b1;
        check("same_valid", 32'(out_valid), 1);
        check("same_data", 32'(out_data), 32'hC3);
        check("same_ovr", 32'(overrun), 0);
        check("same_perr", 32'(parity_err), 1);
        check("same_fe", 32'(frame_err), 1);
        @(posedge clk); #1;
        check("same_drop", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Serial receiver and parity checker. It is the decode end of the XOR-based parity generator path used on the processor's serial debug/IO link.
- Samples one bit per `bit_en` strobe: start bit, DATA_W data bits LSB first, one parity bit, one stop bit.
- Reduces data plus parity with XOR to flag parity errors.
- Presents each received word on a valid/ready output handshake. Sits between the line synchroniser and the IO register file.

Parameters:
- DATA_W, 8, number of data bits per frame (>= 1).
- CNT_W, $clog2(DATA_W) (min 1), bit-counter width; derived, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx  in  1  synchronised serial line; idle high.
- bit_en  in  1  one-cycle strobe marking the bit-sample point.
- out_data  out  DATA_W  received word.
- out_valid  out  1  out_data/status valid; held until accepted.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- parity_err  out  1  parity mismatch for the held word.
- frame_err  out  1  stop bit sampled low for the held word.
- overrun  out  1  sticky; a completed frame was dropped because the previous word was unaccepted.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; shift reg, bit counter, running parity = 0.
  - out_data = 0; out_valid, parity_err, frame_err, overrun = 0.
  - Reset mid-frame abandons the frame with no output.
- FSM: IDLE, DATA, PARITY, STOP. It advances only on cycles with bit_en = 1. rx is ignored when bit_en = 0.
- IDLE:
  - bit_en & rx = 0 → DATA; counter = 0; running parity = 0.
  - bit_en & rx = 1 → stay in IDLE.
- DATA (each bit_en):
  - shift[cnt] = rx; par ^= rx; cnt++.
  - On the sample with cnt == DATA_W-1 → PARITY.
- PARITY (bit_en):
  - perr_next = par ^ rx ^ EXPECT, where EXPECT = 0 for even parity and 1 for odd.
  - → STOP.
- STOP (bit_en): fe_next = ~rx; commit; → IDLE.
  - A low stop bit still commits the word, with frame_err = 1.
  - There is no break/resync handling. The next start is searched from IDLE.
- Commit, applied on the clock edge after the STOP sample:
  - Accept is possible in the same cycle when out_valid & out_ready, or when out_valid = 0.
  - If accept is possible: load out_data/parity_err/frame_err and set out_valid = 1. Latency is exactly 1 clk after the STOP bit_en cycle.
  - If out_valid = 1 & out_ready = 0: the new frame is dropped, held outputs are unchanged, and overrun is set.
- Handshake:
  - out_valid & out_ready with no commit → out_valid = 0 next cycle. out_data and status bits hold their values.
  - out_data, parity_err and frame_err are stable while out_valid = 1 & out_ready = 0.
- overrun clears on the cycle a word is accepted (out_valid & out_ready). If that same cycle has a commit, the commit wins: the word is loaded and overrun stays 0.
- bit_en on consecutive cycles is legal. Minimum frame length is DATA_W+3 strobes.

Optional Feature:
- Macro: SERIAL_PARITY_ODD_EN.
  - Defined: EXPECT = 1 (odd parity; a frame is good when the XOR of data and parity bit = 1).
  - Undefined: EXPECT = 0 (even parity).
- No other behaviour changes.

Decomposition:
- Package serial_link_pkg holds:
  - state enum rx_state_t {IDLE, DATA, PARITY, STOP};
  - localparam default DATA_W = 8;
  - parity-sense constant PARITY_EVEN = 1'b0.
- Shared with the future transmitter.
- One natural sub-module: parity_accum (1-bit XOR accumulator with clear/enable), reusable by the TX side.
- FSM, shift register and handshake stay in the top.

Test Plan:
- DATA_W = 8, even parity. Frame 0,{0xA5 LSB first},par = 0,stop = 1 with out_ready = 1 → out_data = 0xA5, parity_err = 0, frame_err = 0; out_valid pulses 1 clk, one clk after the stop strobe.
- Frame 0x07 with parity bit 0 (three ones, so a mismatch) → out_data = 0x07, parity_err = 1. With SERIAL_PARITY_ODD_EN the same frame gives parity_err = 0.
- Frame 0x3C, par 0, stop = 0 → out_data = 0x3C, frame_err = 1, parity_err = 0.
- out_ready = 0; send 0x11 then 0x22 → out_data stays 0x11, overrun = 1. Raise out_ready → accept 0x11; overrun = 0 and out_valid = 0 next clk.
- Assert reset_n = 0 after 4 data bits of 0xFF, release, then send 0x5A → only 0x5A is delivered with no errors. During reset, all outputs = 0 asynchronously.
- Accept the held word in the same cycle a new frame commits (out_valid = 1, out_ready = 1 on the commit edge) → new word loaded, out_valid stays 1, overrun = 0.
